// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Fetch sequencer that sits between instruction memory and decode. It owns
//   the fetch PC, issues one word read at a time over a req/ack handshake, and
//   hands each instruction to decode with its PC over valid/ready. A one-entry
//   skid buffer catches the instruction that returns while decode is stalled.
//   It also handles branch redirects (flush and refetch) and halt.
//
// Ports
//   clk1_i            clock; all state changes on the rising edge
//   rst_i             synchronous active-high reset
//   imem_req_o        read request; once raised it is held until acked
//   imem_addr_o       read address; held stable while imem_req_o is high
//   imem_ack_i        read done; imem_rdata_i is valid in this cycle
//   imem_rdata_i      instruction word from memory
//   redirect_valid_i  taken branch/jump; flush and refetch from redirect_pc_i
//   redirect_pc_i     redirect target
//   halt_req_i        level; no new fetches are started while high
//   halted_o          high while the sequencer sits in the halted state
//   if_valid_o        if_ir_o/if_pc_o hold an instruction for decode
//   if_ir_o           fetched instruction
//   if_pc_o           address of if_ir_o
//   if_ready_i        decode takes the instruction when if_valid_o && if_ready_i

module fetch_ctrl #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter int unsigned         IR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(1)
) (
  input  logic                clk1_i,
  input  logic                rst_i,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [IR_WIDTH-1:0] imem_rdata_i,
  input  logic                redirect_valid_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  input  logic                halt_req_i,
  output logic                halted_o,
  output logic                if_valid_o,
  output logic [IR_WIDTH-1:0] if_ir_o,
  output logic [PC_WIDTH-1:0] if_pc_o,
  input  logic                if_ready_i
);

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pending_pc_q, pending_pc_d;
  logic                req_active_q, req_active_d;
  logic                out_valid_q, out_valid_d;
  logic [IR_WIDTH-1:0] out_ir_q, out_ir_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                skid_valid_q, skid_valid_d;
  logic [IR_WIDTH-1:0] skid_ir_q, skid_ir_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;

  logic start;
  logic xfer_done;
  logic out_free;

  // A new read only starts when the skid is empty, so whatever comes back
  // always has somewhere to land. The request is masked during reset because
  // the state registers are not yet known on the first reset cycle.
  always_comb begin
    start      = (state_q == ST_FETCH) && !req_active_q && !skid_valid_q &&
                 !halt_req_i && !redirect_valid_i;
    imem_req_o = !rst_i && ((state_q == ST_DRAIN) ||
                            ((state_q == ST_FETCH) && (req_active_q || start)));
    imem_addr_o = pc_q;
    xfer_done  = imem_req_o && imem_ack_i;
    out_free   = !out_valid_q || if_ready_i;
    halted_o   = !rst_i && (state_q == ST_HALTED);
    if_valid_o = out_valid_q;
    if_ir_o    = out_ir_q;
    if_pc_o    = out_pc_q;
  end

  // Next-state logic. The decode drain is applied first, then the FSM case
  // may overwrite the output register with returning data, and a redirect
  // finally wipes both buffers since it has the highest priority.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    req_active_d = req_active_q;
    out_valid_d  = out_valid_q;
    out_ir_d     = out_ir_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_ir_d    = skid_ir_q;
    skid_pc_d    = skid_pc_q;

    if (out_valid_q && if_ready_i) begin
      if (skid_valid_q) begin
        out_ir_d     = skid_ir_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    case (state_q)
      ST_FETCH: begin
        if (redirect_valid_i) begin
          // A read still in flight cannot be withdrawn; park the target and
          // wait for it to finish in DRAIN. If it acks now it is simply dropped.
          if (req_active_q && !imem_ack_i) begin
            pending_pc_d = redirect_pc_i;
            state_d      = ST_DRAIN;
          end else begin
            pc_d         = redirect_pc_i;
            req_active_d = 1'b0;
          end
        end else if (xfer_done) begin
          pc_d         = pc_q + PC_STEP;
          req_active_d = 1'b0;
          if (out_free) begin
            out_valid_d = 1'b1;
            out_ir_d    = imem_rdata_i;
            out_pc_d    = pc_q;
          end else begin
            skid_valid_d = 1'b1;
            skid_ir_d    = imem_rdata_i;
            skid_pc_d    = pc_q;
          end
          if (halt_req_i) begin
            state_d = ST_HALTED;
          end
        end else begin
          if (start) begin
            req_active_d = 1'b1;
          end
          if (halt_req_i && !req_active_q) begin
            state_d = ST_HALTED;
          end
        end
      end

      ST_DRAIN: begin
        // The stale read is completed and its data thrown away. A redirect
        // arriving in the same cycle as the ack is the newest target.
        if (xfer_done) begin
          req_active_d = 1'b0;
          pc_d         = redirect_valid_i ? redirect_pc_i : pending_pc_q;
          state_d      = (halt_req_i && !redirect_valid_i) ? ST_HALTED : ST_FETCH;
        end else if (redirect_valid_i) begin
          pending_pc_d = redirect_pc_i;
        end
      end

      ST_HALTED: begin
        if (redirect_valid_i) begin
          pc_d = redirect_pc_i;
        end
        if (!halt_req_i) begin
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d      = ST_FETCH;
        req_active_d = 1'b0;
      end
    endcase

    if (redirect_valid_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk1_i) begin
    if (rst_i) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      pending_pc_q <= RESET_PC;
      req_active_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_ir_q     <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_ir_q    <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      req_active_q <= req_active_d;
      out_valid_q  <= out_valid_d;
      out_ir_q     <= out_ir_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_ir_q    <= skid_ir_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
//   Drives fetch_ctrl with a latency-configurable memory and random decode
//   stalls, redirects, halts and resets. A reference model tracks the program
//   order of fetches at the instruction level and queues each instruction
//   that must reach decode; a monitor pops that queue on every decode
//   handshake and compares.

module tb_fetch_ctrl;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } item_t;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk1;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_pc;
  logic        if_ready;

  int checkCount = 0;
  int errorCount = 0;
  int popCount   = 0;
  bit seen40     = 1'b0;
  bit armed      = 1'b0;

  item_t expQ[$];

  int reqAge  = 0;
  int curLat  = 0;
  int rstCnt  = 0;
  logic sReq  = 1'b0;
  logic sAck  = 1'b0;

  fetch_ctrl #(
    .PC_WIDTH(32),
    .IR_WIDTH(32),
    .RESET_PC(RESET_PC),
    .PC_STEP (32'd1)
  ) dut (
    .clk1_i          (clk1),
    .rst_i           (rst),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_ack_i      (imem_ack),
    .imem_rdata_i    (imem_rdata),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .halt_req_i      (halt_req),
    .halted_o        (halted),
    .if_valid_o      (if_valid),
    .if_ir_o         (if_ir),
    .if_pc_o         (if_pc),
    .if_ready_i      (if_ready)
  );

  // Memory contents are a fixed scramble of the word address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  always_comb imem_rdata = memWord(imem_addr);

  // Handshake values as they stand just before the coming rising edge.
  always @(negedge clk1) begin
    sReq = imem_req;
    sAck = imem_ack;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  // Modes: 0 zero-wait memory, decode always ready; 1 memory acks after
  // three waiting cycles; 2 fully random; 3 halt and drain;
  // 4 decode stalled with zero-wait memory.
  task automatic applyStimulus(input int mode);
    if (sReq && !sAck) reqAge++;
    else reqAge = 0;
    if (reqAge == 0) begin
      case (mode)
        0, 4:    curLat = 0;
        1:       curLat = 3;
        3:       curLat = 1;
        default: curLat = $urandom_range(0, 3);
      endcase
    end
    imem_ack = (reqAge >= curLat);
    if (mode == 2) begin
      if (rstCnt > 0) begin
        rst = 1'b1;
        rstCnt--;
      end else if ($urandom_range(0, 149) == 0) begin
        rst    = 1'b1;
        rstCnt = 1;
      end else begin
        rst = 1'b0;
      end
      if_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 14) == 0) halt_req = !halt_req;
    end else begin
      rst            = 1'b0;
      rstCnt         = 0;
      redirect_valid = 1'b0;
      if_ready       = (mode != 4);
      halt_req       = (mode == 3);
    end
  endtask

  // Reference model: an instruction-level view of the fetch stream. nextPc
  // is the address the next fetch must use; a redirect that lands while a
  // read is in flight leaves that read to finish unused before the stream
  // moves to the target.
  initial begin : model
    logic [31:0] nextPc;
    logic [31:0] drainTgt;
    bit          drain;
    bit          mHalted;
    logic r, rv, rq, ak, hr;
    logic [31:0] rpc;
    nextPc   = RESET_PC;
    drainTgt = RESET_PC;
    drain    = 1'b0;
    mHalted  = 1'b0;
    forever begin
      @(negedge clk1);
      #1;
      r   = rst;
      rv  = redirect_valid;
      rpc = redirect_pc;
      rq  = imem_req;
      ak  = imem_ack;
      hr  = halt_req;
      if (r) armed = 1'b1;
      if (armed) begin
        if (r) begin
          checkOutput("imem_req during reset", 32'(rq), 32'd0);
        end else begin
          checkOutput("halted", 32'(halted), 32'(mHalted));
          if (mHalted) checkOutput("imem_req while halted", 32'(rq), 32'd0);
          if (rq) checkOutput("imem_addr", imem_addr, nextPc);
        end

        if (r) begin
          expQ.delete();
          nextPc  = RESET_PC;
          drain   = 1'b0;
          mHalted = 1'b0;
        end else if (mHalted) begin
          if (rv) begin
            expQ.delete();
            nextPc = rpc;
          end
          if (!hr) mHalted = 1'b0;
        end else if (rv) begin
          expQ.delete();
          if (drain) begin
            if (rq && ak) begin
              drain  = 1'b0;
              nextPc = rpc;
            end else begin
              drainTgt = rpc;
            end
          end else if (rq && !ak) begin
            drain    = 1'b1;
            drainTgt = rpc;
          end else begin
            nextPc = rpc;
          end
        end else if (rq && ak) begin
          if (drain) begin
            drain  = 1'b0;
            nextPc = drainTgt;
          end else begin
            expQ.push_back('{ir: memWord(nextPc), pc: nextPc});
            nextPc = nextPc + 32'd1;
          end
          mHalted = hr;
        end else if (!rq) begin
          mHalted = hr;
        end else begin
          mHalted = 1'b0;
        end
      end
    end
  end

  // Monitor: every decode handshake that is not being flushed must match
  // the oldest instruction the model expects.
  always @(negedge clk1) begin
    item_t exp;
    if (armed && !rst && !redirect_valid && if_valid && if_ready) begin
      if (expQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL unexpected output: got pc 0x%08h ir 0x%08h, required no output (t=%0t)",
                 if_pc, if_ir, $time);
      end else begin
        exp = expQ.pop_front();
        checkOutput("if_pc", if_pc, exp.pc);
        checkOutput("if_ir", if_ir, exp.ir);
        popCount++;
        if (exp.pc == 32'h40) seen40 = 1'b1;
      end
    end
  end

  initial begin : main
    int pops0;
    bit done;
    rst            = 1'b1;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt_req       = 1'b0;
    if_ready       = 1'b0;

    repeat (3) @(posedge clk1);
    @(negedge clk1);
    checkOutput("reset if_valid", 32'(if_valid), 32'd0);
    checkOutput("reset if_ir", if_ir, 32'd0);
    checkOutput("reset if_pc", if_pc, 32'd0);
    checkOutput("reset halted", 32'(halted), 32'd0);
    checkOutput("reset imem_req", 32'(imem_req), 32'd0);

    // Zero-wait memory, decode always ready: one instruction per cycle.
    pops0 = popCount;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk1); #1;
      applyStimulus(0);
    end
    @(negedge clk1);
    checkOutput("zero-wait throughput >= 35", 32'(popCount - pops0 >= 35), 32'd1);

    // Decode stalls: output and skid fill, fetching stops.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk1); #1;
      applyStimulus(4);
    end
    @(negedge clk1);
    checkOutput("stalled imem_req", 32'(imem_req), 32'd0);
    checkOutput("stalled if_valid", 32'(if_valid), 32'd1);

    // Slow memory: one instruction every four cycles.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk1); #1;
      applyStimulus(1);
    end
    pops0 = popCount;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk1); #1;
      applyStimulus(1);
    end
    @(negedge clk1);
    checkOutput("slow-memory pops in [9,11]",
                32'((popCount - pops0 >= 9) && (popCount - pops0 <= 11)), 32'd1);

    // Redirect to 0x40 while a slow read is in flight.
    done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(posedge clk1); #1;
      applyStimulus(1);
      if (reqAge == 1) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        done           = 1'b1;
      end
    end
    checkOutput("redirect opportunity found", 32'(done), 32'd1);
    @(negedge clk1);
    @(negedge clk1);
    checkOutput("flushed if_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk1); #1;
      applyStimulus(1);
    end
    @(negedge clk1);
    checkOutput("instruction at 0x40 delivered", 32'(seen40), 32'd1);

    // Random traffic with redirects, halts, stalls and resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk1); #1;
      applyStimulus(2);
    end

    // Halt and drain: every queued instruction must have been delivered.
    for (int i = 0; i < 30; i++) begin
      @(posedge clk1); #1;
      applyStimulus(3);
    end
    @(negedge clk1);
    #2;
    checkOutput("final queue empty", 32'(expQ.size()), 32'd0);
    checkOutput("final if_valid", 32'(if_valid), 32'd0);
    checkOutput("final halted", 32'(halted), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
